// File: rtl/pipeline_ifr_buffer.sv
// Instruction-fetch-ready buffer: a DEPTH-entry FIFO between IFP and decode that
// selects each fetched instruction from one of NCH channels and back-pressures on not-ready channels.
module pipeline_ifr_buffer #(
  parameter int              XLEN  = 64,
  parameter int              ILEN  = 32,
  parameter int              NCH   = 2,
  parameter int              DEPTH = 4,
  parameter logic [ILEN-1:0] NOP   = 32'h00000013,
  localparam int             CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int             PW    = $clog2(DEPTH),
  localparam int             CW    = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                req_valid,
  input  logic [XLEN-1:0]     req_pc,
  input  logic [CHW-1:0]      req_ch,
  output logic                req_ready,
  input  logic [NCH*ILEN-1:0] ch_dout,
  input  logic [NCH-1:0]      ch_ready,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_pc,
  output logic [ILEN-1:0]     out_instr,
  output logic                out_err,
  input  logic                out_ready,
  output logic [CW-1:0]       count,
  output logic [31:0]         wait_cycles
);

  localparam int EW = XLEN + ILEN + 1;

  logic [ILEN-1:0] w_ch_data [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch_unpack
      assign w_ch_data[gi] = ch_dout[gi*ILEN +: ILEN];
    end
  endgenerate

  logic            w_legal;
  logic            w_rdy;
  logic [ILEN-1:0] w_data;

  // An index with no matching channel is illegal: it reads as zero and never stalls.
  always_comb begin
    w_legal = 1'b0;
    w_rdy   = 1'b1;
    w_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (req_ch == CHW'(i)) begin
        w_legal = 1'b1;
        w_rdy   = ch_ready[i];
        w_data  = w_ch_data[i];
      end
    end
  end

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_wait;
  logic          r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [ILEN-1:0] r_out_instr;
  logic          r_out_err;

  logic          w_not_full;
  logic          w_pop;
  logic          w_push;
  logic [EW-1:0] w_wr_entry;
  logic [PW-1:0] w_rd_next;
  logic [CW-1:0] w_count_next;
  logic [EW-1:0] w_head_next;
  logic          w_wait_inc;

  assign w_not_full = (r_count != CW'(DEPTH));
  assign w_pop      = r_out_valid && out_ready && !flush;
  assign req_ready  = w_rdy && !flush && (w_not_full || w_pop);
  assign w_push     = req_valid && req_ready;
  assign w_wr_entry = {req_pc, w_data, !w_legal};
  assign w_rd_next  = r_rd_ptr + PW'(w_pop);

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Head is read from the post-update read pointer; bypass the write when the
  // entry being pushed becomes the head in the same cycle.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = w_wr_entry;
    end
  end

  assign w_wait_inc = req_valid && w_legal && !w_rdy && !flush && (r_wait != 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wait   <= '0;
    end else begin
      if (w_wait_inc) begin
        r_wait <= r_wait + 32'd1;
      end
      r_count <= w_count_next;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(w_push);
        r_rd_ptr <= w_rd_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= NOP;
      r_out_err   <= 1'b0;
    end else if (flush || (w_count_next == '0)) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= NOP;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= 1'b1;
      r_out_pc    <= w_head_next[EW-1 -: XLEN];
      r_out_instr <= w_head_next[ILEN:1];
      r_out_err   <= w_head_next[0];
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign out_err     = r_out_err;
  assign count       = r_count;
  assign wait_cycles = r_wait;

endmodule

// File: tb/tb_pipeline_ifr_buffer.sv
// Directed bench for pipeline_ifr_buffer (NCH=3 so an illegal channel index is reachable).
module tb_pipeline_ifr_buffer;

  localparam int XLEN = 64, ILEN = 32, NCH = 3, DEPTH = 4;
  localparam logic [31:0] NOPV = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset, flush, req_valid, req_ready, out_valid, out_err, out_ready;
  logic [XLEN-1:0] req_pc, out_pc;
  logic [1:0]      req_ch;
  logic [NCH*ILEN-1:0] ch_dout;
  logic [NCH-1:0]  ch_ready;
  logic [ILEN-1:0] out_instr;
  logic [2:0]      count;
  logic [31:0]     wait_cycles;

  int total = 0;
  int bad   = 0;

  pipeline_ifr_buffer #(.XLEN(XLEN), .ILEN(ILEN), .NCH(NCH), .DEPTH(DEPTH), .NOP(NOPV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_pc(req_pc), .req_ch(req_ch), .req_ready(req_ready),
    .ch_dout(ch_dout), .ch_ready(ch_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_err(out_err),
    .out_ready(out_ready), .count(count), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s = %0h", tag, obs);
    end else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] d);
    ch_dout[ch*ILEN +: ILEN] = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0; req_ch = '0;
    ch_dout = '0; ch_ready = 3'b111; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_instr", 64'(out_instr), 64'(NOPV));
    check("rst_err", 64'(out_err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wait", 64'(wait_cycles), 64'd0);

    // ROM stream with continuous consumption
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_ch = 2'd0; req_pc = 64'h1000 + 64'(4*k); set_ch(0, 32'hA + 32'(k));
      #1 check("rom_ready", 64'(req_ready), 64'd1);
      step();
      check("rom_valid", 64'(out_valid), 64'd1);
      check("rom_pc", out_pc, 64'h1000 + 64'(4*k));
      check("rom_instr", 64'(out_instr), 64'hA + 64'(k));
      check("rom_count", 64'(count), 64'd1);
    end
    req_valid = 1'b0;
    step();
    check("rom_drain_valid", 64'(out_valid), 64'd0);
    check("rom_drain_instr", 64'(out_instr), 64'(NOPV));

    // DRAM channel not ready for three cycles
    req_valid = 1'b1; req_ch = 2'd1; req_pc = 64'h2000; set_ch(1, 32'hDEADBEEF); ch_ready = 3'b101;
    for (int k = 0; k < 3; k++) begin
      #1 check("dram_stall_ready", 64'(req_ready), 64'd0);
      step();
      check("dram_stall_count", 64'(count), 64'd0);
    end
    check("dram_wait", 64'(wait_cycles), 64'd3);
    ch_ready = 3'b111;
    #1 check("dram_ready", 64'(req_ready), 64'd1);
    step();
    check("dram_pc", out_pc, 64'h2000);
    check("dram_instr", 64'(out_instr), 64'hDEADBEEF);
    check("dram_wait_hold", 64'(wait_cycles), 64'd3);
    req_valid = 1'b0;
    step();
    check("dram_one_entry", 64'(count), 64'd0);

    // Fill with decode stalled, then release
    out_ready = 1'b0; req_ch = 2'd0; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_pc = 64'h3000 + 64'(4*k); set_ch(0, 32'h300 + 32'(k));
      #1 check("fill_ready", 64'(req_ready), 64'd1);
      step();
    end
    check("fill_count", 64'(count), 64'd4);
    req_pc = 64'h3010; set_ch(0, 32'h304);
    #1 check("full_ready", 64'(req_ready), 64'd0);
    step();
    check("full_count", 64'(count), 64'd4);
    check("full_head_stable", out_pc, 64'h3000);
    out_ready = 1'b1;
    #1 check("full_pop_ready", 64'(req_ready), 64'd1);
    step();
    check("full_swap_count", 64'(count), 64'd4);
    req_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check("drain_pc", out_pc, 64'h3000 + 64'(4*k));
      check("drain_instr", 64'(out_instr), 64'h300 + 64'(k));
      step();
    end
    check("drain_count", 64'(count), 64'd0);

    // Flush with three entries buffered and a fetch presented
    out_ready = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_pc = 64'h4000 + 64'(4*k); set_ch(0, 32'h400 + 32'(k));
      step();
    end
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; req_pc = 64'h400C; set_ch(0, 32'h403);
    #1 check("flush_ready", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_instr", 64'(out_instr), 64'(NOPV));
    check("flush_count", 64'(count), 64'd0);
    out_ready = 1'b1;
    step();
    check("flush_absent", 64'(count), 64'd0);
    req_valid = 1'b1; req_pc = 64'h4100; set_ch(0, 32'h410);
    step();
    check("post_flush_pc", out_pc, 64'h4100);

    // Illegal channel index: accepted at once, zero data, error flag
    req_ch = 2'd3; req_pc = 64'h5000; ch_ready = 3'b000;
    #1 check("illegal_ready", 64'(req_ready), 64'd1);
    step();
    check("illegal_pc", out_pc, 64'h5000);
    check("illegal_instr", 64'(out_instr), 64'd0);
    check("illegal_err", 64'(out_err), 64'd1);
    check("illegal_no_wait", 64'(wait_cycles), 64'd3);
    req_valid = 1'b0; ch_ready = 3'b111; req_ch = 2'd0;
    step();
    check("illegal_drain", 64'(count), 64'd0);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0; req_valid = 1'b1;
    req_pc = 64'h6000; step();
    req_pc = 64'h6004; step();
    req_ch = 2'd1; ch_ready = 3'b101; req_pc = 64'h6008;
    step();
    check("pre_rst_count", 64'(count), 64'd2);
    check("pre_rst_wait", 64'(wait_cycles), 64'd4);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_pc", out_pc, 64'd0);
    check("arst_instr", 64'(out_instr), 64'(NOPV));
    check("arst_err", 64'(out_err), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_wait", 64'(wait_cycles), 64'd0);
    step();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
